// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: output/OE registers with atomic set/clear, synchronised and
// optionally debounced inputs, per-channel rise/fall capture into a sticky STATUS driving irq.
module gpio_ctrl #(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      SYNC_STAGES  = 2,
   parameter int unsigned      DEBOUNCE_DIV = 0,
   parameter logic [WIDTH-1:0] RESET_OUT    = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             bus_req,
   input  logic             bus_write,
   input  logic [2:0]       bus_address,
   input  logic [31:0]      bus_wdata,
   output logic             bus_ack,
   output logic [31:0]      bus_rdata,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   typedef enum logic [2:0] {
      ADDR_OUT     = 3'd0,
      ADDR_OE      = 3'd1,
      ADDR_IN      = 3'd2,
      ADDR_RISE_EN = 3'd3,
      ADDR_FALL_EN = 3'd4,
      ADDR_STATUS  = 3'd5,
      ADDR_OUT_SET = 3'd6,
      ADDR_OUT_CLR = 3'd7
   } addr_e;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_w;
   logic [WIDTH-1:0] deb_w;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_w = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_DIV == 0) begin : g_no_debounce
         assign deb_w = sync_w;
      end else begin : g_debounce
         localparam int unsigned   CW     = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
         localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_DIV - 1);

         logic [CW-1:0]    cnt_q;
         logic [WIDTH-1:0] samp_q;
         logic [WIDTH-1:0] deb_q;
         logic [WIDTH-1:0] stable_w;

         // A channel follows its input only once two consecutive tick samples agree.
         assign stable_w = ~(sync_w ^ samp_q);

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_q  <= '0;
               samp_q <= '0;
               deb_q  <= '0;
            end else if (cnt_q == '0) begin
               cnt_q  <= RELOAD;
               samp_q <= sync_w;
               deb_q  <= (sync_w & stable_w) | (deb_q & ~stable_w);
            end else begin
               cnt_q  <= cnt_q - CW'(1);
            end
         end

         assign deb_w = deb_q;
      end
   endgenerate

   logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q, prev_q;
   logic             ack_q, irq_q;
   logic [31:0]      rdata_d, rdata_q;
   logic             wr_en_w;
   logic [WIDTH-1:0] wdata_w, hit_w, w1c_w;
   logic             unused_wdata;

   assign unused_wdata = ^bus_wdata;
   assign wr_en_w      = bus_req & bus_write;
   assign wdata_w      = bus_wdata[WIDTH-1:0];
   assign hit_w        = (deb_w & ~prev_q & rise_en_q) | (~deb_w & prev_q & fall_en_q);
   assign w1c_w        = (wr_en_w && addr_e'(bus_address) == ADDR_STATUS) ? wdata_w : '0;

   always_comb begin
      rdata_d = '0;
      if (bus_req && !bus_write) begin
         case (addr_e'(bus_address))
            ADDR_OUT:     rdata_d[WIDTH-1:0] = out_q;
            ADDR_OE:      rdata_d[WIDTH-1:0] = oe_q;
            ADDR_IN:      rdata_d[WIDTH-1:0] = deb_w;
            ADDR_RISE_EN: rdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN: rdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_STATUS:  rdata_d[WIDTH-1:0] = status_q;
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_q     <= RESET_OUT;
         oe_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         prev_q    <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         ack_q    <= bus_req;
         rdata_q  <= rdata_d;
         prev_q   <= deb_w;
         // A fresh edge wins over a same-cycle W1C of that bit.
         status_q <= (status_q & ~w1c_w) | hit_w;
         irq_q    <= |status_q;
         if (wr_en_w) begin
            case (addr_e'(bus_address))
               ADDR_OUT:     out_q     <= wdata_w;
               ADDR_OE:      oe_q      <= wdata_w;
               ADDR_RISE_EN: rise_en_q <= wdata_w;
               ADDR_FALL_EN: fall_en_q <= wdata_w;
               ADDR_OUT_SET: out_q     <= out_q | wdata_w;
               ADDR_OUT_CLR: out_q     <= out_q & ~wdata_w;
               default:      ;
            endcase
         end
      end
   end

   assign bus_ack   = ack_q;
   assign bus_rdata = rdata_q;
   assign gpio_o    = out_q;
   assign gpio_oe   = oe_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: directed scenarios on an undebounced and a debounced instance,
// then random bus/pin traffic checked cycle by cycle against a pin-history reference model.
module tb_gpio_ctrl;
   localparam int W = 8;
   localparam logic [W-1:0] RST_OUT = 8'h3C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic req0, wr0, ack0, irq0;
   logic [2:0] addr0;
   logic [31:0] wd0, rd0;
   logic [W-1:0] pin0, o0, oe0;
   logic req1, wr1, ack1, irq1;
   logic [2:0] addr1;
   logic [31:0] wd1, rd1;
   logic [W-1:0] pin1, o1, oe1;

   int vectors = 0;
   int errors  = 0;

   gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_DIV(0), .RESET_OUT(RST_OUT)) u_dut0 (
      .clk(clk), .reset_n(rst_n), .bus_req(req0), .bus_write(wr0), .bus_address(addr0),
      .bus_wdata(wd0), .bus_ack(ack0), .bus_rdata(rd0), .gpio_i(pin0), .gpio_o(o0),
      .gpio_oe(oe0), .irq(irq0));

   gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_DIV(16), .RESET_OUT(RST_OUT)) u_dut16 (
      .clk(clk), .reset_n(rst_n), .bus_req(req1), .bus_write(wr1), .bus_address(addr1),
      .bus_wdata(wd1), .bus_ack(ack1), .bus_rdata(rd1), .gpio_i(pin1), .gpio_o(o1),
      .gpio_oe(oe1), .irq(irq1));

   task automatic bus(input int d, input logic w, input logic [2:0] a, input logic [31:0] data);
      if (d == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wd0 = data; end
      else        begin req1 = 1'b1; wr1 = w; addr1 = a; wd1 = data; end
      @(posedge clk); #1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd0;
      idle(3);
      vectors++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack0); end
      vectors++; if (o0 !== RST_OUT) begin errors++; $display("FAIL reset_out: got %h expected %h", o0, RST_OUT); end
      vectors++; if (oe0 !== '0) begin errors++; $display("FAIL reset_oe: got %h expected 00", oe0); end
      vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq0); end
      vectors++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rd0); end
      vectors++; if (o1 !== RST_OUT) begin errors++; $display("FAIL reset_out16: got %h expected %h", o1, RST_OUT); end
      req0 = 1'b0; rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_out_setclr();
      bus(0, 1'b1, 3'd0, 32'hFFFF_FFA5);
      vectors++; if (o0 !== 8'hA5) begin errors++; $display("FAIL out_write: got %h expected a5", o0); end
      vectors++; if (ack0 !== 1'b1) begin errors++; $display("FAIL write_ack: got %b expected 1", ack0); end
      bus(0, 1'b1, 3'd6, 32'h0000_000F);
      vectors++; if (o0 !== 8'hAF) begin errors++; $display("FAIL out_set: got %h expected af", o0); end
      bus(0, 1'b1, 3'd7, 32'h0000_0081);
      vectors++; if (o0 !== 8'h2E) begin errors++; $display("FAIL out_clr: got %h expected 2e", o0); end
      bus(0, 1'b0, 3'd0, 32'h0);
      vectors++; if (ack0 !== 1'b1) begin errors++; $display("FAIL read_ack: got %b expected 1", ack0); end
      vectors++; if (rd0 !== 32'h0000_002E) begin errors++; $display("FAIL read_out: got %h expected 2e", rd0); end
      idle(1);
      vectors++; if (ack0 !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", ack0); end
      bus(0, 1'b1, 3'd1, 32'h0000_005A);
      vectors++; if (oe0 !== 8'h5A) begin errors++; $display("FAIL oe_write: got %h expected 5a", oe0); end
      bus(0, 1'b1, 3'd2, 32'hFFFF_FFFF);
      bus(0, 1'b0, 3'd2, 32'h0);
      vectors++; if (rd0 !== 32'h0) begin errors++; $display("FAIL in_write_ignored: got %h expected 0", rd0); end
      bus(0, 1'b0, 3'd6, 32'h0);
      vectors++; if (rd0 !== 32'h0) begin errors++; $display("FAIL set_reads_zero: got %h expected 0", rd0); end
   endtask

   task automatic test_rise_irq();
      bus(0, 1'b1, 3'd3, 32'h1);
      pin0[0] = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd2;
      idle(2);
      vectors++; if (rd0[0] !== 1'b0) begin errors++; $display("FAIL in_latency_early: got %b expected 0", rd0[0]); end
      idle(1);
      vectors++; if (rd0[0] !== 1'b1) begin errors++; $display("FAIL in_latency: got %b expected 1", rd0[0]); end
      vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq0); end
      req0 = 1'b0;
      idle(1);
      vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq0); end
      bus(0, 1'b0, 3'd5, 32'h0);
      vectors++; if (rd0 !== 32'h1) begin errors++; $display("FAIL status_rise: got %h expected 1", rd0); end
      bus(0, 1'b1, 3'd5, 32'h1);
      vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_hold_w1c: got %b expected 1", irq0); end
      idle(1);
      vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq0); end
   endtask

   task automatic test_w1c_race();
      bus(0, 1'b1, 3'd4, 32'h4);
      pin0[2] = 1'b1; idle(4);
      pin0[2] = 1'b0; idle(4);
      vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_fall: got %b expected 1", irq0); end
      pin0[2] = 1'b1; idle(4);
      pin0[2] = 1'b0; idle(2);
      bus(0, 1'b1, 3'd5, 32'h4);
      vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL race_irq0: got %b expected 1", irq0); end
      idle(1);
      vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL race_irq1: got %b expected 1", irq0); end
      bus(0, 1'b0, 3'd5, 32'h0);
      vectors++; if (rd0 !== 32'h4) begin errors++; $display("FAIL race_status: got %h expected 4", rd0); end
      bus(0, 1'b1, 3'd5, 32'h4);
      idle(1);
      vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL race_clear: got %b expected 0", irq0); end
   endtask

   task automatic test_no_retro();
      pin0[5] = 1'b1; idle(5);
      bus(0, 1'b1, 3'd3, 32'h21);
      idle(3);
      vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL retro_irq: got %b expected 0", irq0); end
      bus(0, 1'b0, 3'd5, 32'h0);
      vectors++; if (rd0 !== 32'h0) begin errors++; $display("FAIL retro_status: got %h expected 0", rd0); end
      pin0[5] = 1'b0; idle(3);
      pin0[5] = 1'b1; idle(4);
      bus(0, 1'b1, 3'd3, 32'h0);
      bus(0, 1'b0, 3'd5, 32'h0);
      vectors++; if (rd0 !== 32'h20) begin errors++; $display("FAIL en_clear_keeps: got %h expected 20", rd0); end
      bus(0, 1'b1, 3'd5, 32'hFF);
   endtask

   task automatic test_debounce();
      int  n;
      bit  found;
      bus(1, 1'b1, 3'd3, 32'h8);
      pin1[3] = 1'b1; idle(5);
      pin1[3] = 1'b0; idle(40);
      bus(1, 1'b0, 3'd2, 32'h0);
      vectors++; if (rd1 !== 32'h0) begin errors++; $display("FAIL glitch_in: got %h expected 0", rd1); end
      vectors++; if (irq1 !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq1); end
      pin1[3] = 1'b1; req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd2;
      found = 1'b0; n = 0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         if (!found && rd1[3] === 1'b1) begin found = 1'b1; n = k; end
      end
      req1 = 1'b0;
      vectors++;
      if (!found || n < 19 || n > 35) begin
         errors++; $display("FAIL debounce_latency: got %0d cycles (found=%0d) expected 19..35", n, found);
      end
      idle(2);
      vectors++; if (irq1 !== 1'b1) begin errors++; $display("FAIL debounce_irq: got %b expected 1", irq1); end
   endtask

   task automatic test_reset_mid_access();
      bus(0, 1'b1, 3'd0, 32'hFF);
      vectors++; if (o0 !== 8'hFF) begin errors++; $display("FAIL pre_reset_out: got %h expected ff", o0); end
      req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd0; wd0 = 32'h11; rst_n = 1'b0;
      @(posedge clk); #1;
      vectors++; if (ack0 !== 1'b0) begin errors++; $display("FAIL midreset_ack: got %b expected 0", ack0); end
      vectors++; if (o0 !== RST_OUT) begin errors++; $display("FAIL midreset_out: got %h expected %h", o0, RST_OUT); end
      req0 = 1'b0; rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_random();
      logic [W-1:0] m_out, m_oe, m_ren, m_fen, m_st, deb, prv, ev, clr, wv;
      logic         m_irq, m_ack;
      logic [31:0]  m_rd;
      logic [W-1:0] hist[$];
      for (int i = 0; i < 600; i++) begin
         rst_n = (i < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
         req0  = 1'($urandom_range(0, 1));
         wr0   = 1'($urandom_range(0, 1));
         addr0 = 3'($urandom_range(0, 7));
         wd0   = $urandom;
         for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) pin0[b] = ~pin0[b];
         @(posedge clk);
         if (!rst_n) begin
            m_out = RST_OUT; m_oe = '0; m_ren = '0; m_fen = '0; m_st = '0;
            m_irq = 1'b0; m_ack = 1'b0; m_rd = '0;
            hist = '{'0, '0, '0};
         end else begin
            deb = hist[1];
            prv = hist[2];
            wv  = wd0[W-1:0];
            ev  = (deb & ~prv & m_ren) | (~deb & prv & m_fen);
            m_rd = '0;
            if (req0 && !wr0) begin
               case (addr0)
                  3'd0: m_rd = {24'h0, m_out};
                  3'd1: m_rd = {24'h0, m_oe};
                  3'd2: m_rd = {24'h0, deb};
                  3'd3: m_rd = {24'h0, m_ren};
                  3'd4: m_rd = {24'h0, m_fen};
                  3'd5: m_rd = {24'h0, m_st};
                  default: m_rd = '0;
               endcase
            end
            m_irq = (m_st != '0);
            clr   = (req0 && wr0 && addr0 == 3'd5) ? wv : '0;
            m_st  = (m_st & ~clr) | ev;
            if (req0 && wr0) begin
               case (addr0)
                  3'd0: m_out = wv;
                  3'd1: m_oe  = wv;
                  3'd3: m_ren = wv;
                  3'd4: m_fen = wv;
                  3'd6: m_out = m_out | wv;
                  3'd7: m_out = m_out & ~wv;
                  default: ;
               endcase
            end
            m_ack = req0;
            hist.push_front(pin0);
            void'(hist.pop_back());
         end
         #1;
         vectors++;
         if ({ack0, rd0, o0, oe0, irq0} !== {m_ack, m_rd, m_out, m_oe, m_irq}) begin
            errors++;
            $display("FAIL random cycle %0d: got ack=%b rd=%h o=%h oe=%h irq=%b expected ack=%b rd=%h o=%h oe=%h irq=%b",
                     i, ack0, rd0, o0, oe0, irq0, m_ack, m_rd, m_out, m_oe, m_irq);
         end
      end
      req0 = 1'b0; rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; pin0 = '0;
      req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; pin1 = '0;
      @(posedge clk); #1;
      test_reset();
      test_out_setclr();
      test_rise_irq();
      test_w1c_race();
      test_no_retro();
      test_debounce();
      test_reset_mid_access();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
